// File: rtl/cordic_check_pkg.sv
// rtl/cordic_check_pkg.sv - shared types and helpers for the CORDIC check sequencer
//
// Purpose: state encoding, phase index constants and the phase-index to
// one-hot mapping used by cordic_check_sequencer.
// Ports: none (package).
package cordic_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELFTEST = 3'd1,
        ST_CHECK    = 3'd2,
        ST_RETRY    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef logic [2:0] ph_idx_t;

    localparam ph_idx_t PH_A2 = 3'd0;
    localparam ph_idx_t PH_A3 = 3'd1;
    localparam ph_idx_t PH_A4 = 3'd2;
    localparam ph_idx_t PH_A5 = 3'd3;
    localparam ph_idx_t PH_A6 = 3'd4;

    // Bit 0 of the result drives a2, bit 4 drives a6.
    function automatic logic [4:0] phase_onehot(input ph_idx_t idx);
        logic [4:0] oh;
        oh = 5'b00000;
        case (idx)
            PH_A2:   oh = 5'b00001;
            PH_A3:   oh = 5'b00010;
            PH_A4:   oh = 5'b00100;
            PH_A5:   oh = 5'b01000;
            PH_A6:   oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cordic_sat_counter.sv
// rtl/cordic_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses and sticks at all-ones instead of wrapping.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   clr_i    synchronous clear (same effect as reset)
//   inc_i    increment request for this cycle
//   count_o  current count, W bits
module cordic_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cordic_check_sequencer.sv
// rtl/cordic_check_sequencer.sv - phase sequencer and verdict logic for the CORDIC checker
//
// Purpose: steps the combinational CORDIC consistency checker through a
// self-test and ITERS rounds of phases a2..a6, retries an iteration on a
// mismatch up to MAX_RETRY times, and reports pass/fault per operation.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               operation request, honoured only in IDLE
//   d, dn               checker mismatch / clean flags, sampled every edge
//   a2..a6              one-hot phase code to the checker
//   v                   self-test strobe to the checker
//   busy, done          activity level and one-cycle completion pulse
//   pass, fault         verdicts, held until the next accepted start
//   iter, retry_cnt     current iteration and retries used
//   err_cnt             saturating mismatch count for this operation
module cordic_check_sequencer
    import cordic_check_pkg::*;
#(
    parameter int ITERS     = 8,
    parameter int MAX_RETRY = 2,
    parameter int ERRW      = 8,
    localparam int IW       = (ITERS > 1) ? $clog2(ITERS) : 1,
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            d,
    input  logic            dn,
    output logic            a2,
    output logic            a3,
    output logic            a4,
    output logic            a5,
    output logic            a6,
    output logic            v,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fault,
    output logic [IW-1:0]   iter,
    output logic [RW-1:0]   retry_cnt,
    output logic [ERRW-1:0] err_cnt
);

    state_e        state_q;
    ph_idx_t       ph_idx_q;
    logic [4:0]    phase_q;
    logic          v_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          fault_q;
    logic [IW-1:0] iter_q;
    logic [RW-1:0] retry_q;

    logic          clean;
    logic          mismatch;
    logic          err_clr;
    logic          err_inc;
    ph_idx_t       ph_next;

    assign clean    = !d && dn;
    assign mismatch = d && !dn;
    assign err_clr  = (state_q == ST_IDLE) && start;
    assign err_inc  = (state_q == ST_CHECK) && mismatch;
    assign ph_next  = ph_idx_t'(ph_idx_q + 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ph_idx_q <= PH_A2;
            phase_q  <= 5'b00000;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fault_q  <= 1'b0;
            iter_q   <= '0;
            retry_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SELFTEST;
                        v_q     <= 1'b1;
                        phase_q <= phase_onehot(PH_A2);
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fault_q <= 1'b0;
                        iter_q  <= '0;
                        retry_q <= '0;
                    end
                end
                ST_SELFTEST: begin
                    v_q <= 1'b0;
                    // A healthy checker must flag the forced self-test mismatch.
                    if (d) begin
                        state_q  <= ST_CHECK;
                        ph_idx_q <= PH_A2;
                        phase_q  <= phase_onehot(PH_A2);
                    end else begin
                        state_q <= ST_DONE;
                        phase_q <= 5'b00000;
                        fault_q <= 1'b1;
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (clean) begin
                        if (ph_idx_q == PH_A6) begin
                            if (iter_q == IW'(ITERS - 1)) begin
                                state_q <= ST_DONE;
                                phase_q <= 5'b00000;
                                pass_q  <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                iter_q   <= iter_q + IW'(1);
                                ph_idx_q <= PH_A2;
                                phase_q  <= phase_onehot(PH_A2);
                            end
                        end else begin
                            ph_idx_q <= ph_next;
                            phase_q  <= phase_onehot(ph_next);
                        end
                    end else if (mismatch) begin
                        state_q <= ST_RETRY;
                        phase_q <= 5'b00000;
                    end else begin
                        // d and dn agree: the checker itself is broken.
                        state_q <= ST_DONE;
                        phase_q <= 5'b00000;
                        fault_q <= 1'b1;
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_RETRY: begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_q  <= retry_q + RW'(1);
                        state_q  <= ST_CHECK;
                        ph_idx_q <= PH_A2;
                        phase_q  <= phase_onehot(PH_A2);
                    end else begin
                        state_q <= ST_DONE;
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= 5'b00000;
                    v_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    cordic_sat_counter #(
        .W (ERRW)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (err_clr),
        .inc_i   (err_inc),
        .count_o (err_cnt)
    );

    assign a2        = phase_q[0];
    assign a3        = phase_q[1];
    assign a4        = phase_q[2];
    assign a5        = phase_q[3];
    assign a6        = phase_q[4];
    assign v         = v_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fault     = fault_q;
    assign iter      = iter_q;
    assign retry_cnt = retry_q;

endmodule

// File: doc/cordic_check_sequencer.md
# cordic_check_sequencer

- Drives the phase code (a2..a6) and self-test strobe (v) into the combinational CORDIC consistency checker.
- Samples the checker's d (mismatch) and dn (clean) outputs every cycle.
- Issues a bounded retry when a mismatch is reported, and gives a per-operation pass/fault verdict.
- Sits directly upstream of the checker and downstream of the CORDIC datapath controller, which issues `start` once the x/y/z/ex/ey slices are stable.

## Interface
Parameters:
- ITERS, 8, CORDIC iterations checked per operation (≥1)
- MAX_RETRY, 2, retry budget per operation (≥0)
- ERRW, 8, error-counter width

Ports:
- clk  in  1  single clock; all flops rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request; accepted only in IDLE
- d  in  1  checker mismatch flag
- dn  in  1  checker clean flag
- a2, a3, a4, a5, a6  out  1 each  one-hot phase code to checker
- v  out  1  self-test strobe to checker
- busy  out  1  high from SELFTEST through DONE inclusive
- done  out  1  one-cycle completion pulse
- pass  out  1  verdict; held until next accepted start
- fault  out  1  checker hardware fault; held until next accepted start
- iter  out  $clog2(ITERS) (min 1)  current iteration index
- retry_cnt  out  $clog2(MAX_RETRY+1) (min 1)  retries used this operation
- err_cnt  out  ERRW  mismatches this operation, saturating at all-ones

## Operation
- All outputs are registered Moore outputs of the FSM and counters.
- d and dn are combinational functions of those outputs and are sampled on the next clk edge.
- Reset: state IDLE; a2..a6, v, busy, done, pass, fault = 0; iter, retry_cnt, err_cnt = 0. A reset mid-operation aborts the operation and emits no done.

States:
- IDLE: all phase lines and v low; the checker's all-zero phase is expected to give dn=1 (not checked). start=1 → SELFTEST; clears pass, fault, iter, retry_cnt, err_cnt.
- SELFTEST (1 cycle): v=1, a2=1.
  - Sampled d=1 → CHECK with phase a2, iter 0.
  - Sampled d=0 → fault=1, pass=0 → DONE.
- CHECK: v=0; exactly one of a2,a3,a4,a5,a6 high, advancing in that order one per cycle. Sampled (d,dn):
  - (0,1) clean: advance phase. After a6 the phase wraps to a2 and iter increments. a6 clean with iter=ITERS-1 → pass=1 → DONE.
  - (1,0) mismatch: err_cnt increments (saturating) → RETRY.
  - (0,0) or (1,1) inconsistent: fault=1, pass=0 → DONE. err_cnt is unchanged.
- RETRY (1 cycle): all phase lines low.
  - retry_cnt < MAX_RETRY: retry_cnt increments → CHECK at a2 of the same iter.
  - Otherwise: pass=0 → DONE.
- DONE (1 cycle): done=1 → IDLE. pass and fault persist into IDLE.

Input rules:
- start while busy is ignored; it is not queued.
- start high on the DONE cycle is ignored; start is re-sampled in IDLE.
- pass and fault are never both 1.

## Timing
- start sampled high in IDLE at edge T. SELFTEST occupies cycle T+1; CHECK starts at T+2.
- Error-free operation: CHECK spans 5·ITERS cycles and done=1 in cycle T+2+5·ITERS. For ITERS=8 that is T+42.
- Each retry adds 1 (RETRY) + k cycles, where k is the number of phases re-executed in that iteration.
- A fault in SELFTEST gives done at T+2.
- busy rises the cycle after start acceptance and falls the cycle after done.

## Structure
- Package cordic_check_pkg holds:
  - the state enum (IDLE, SELFTEST, CHECK, RETRY, DONE)
  - phase index constants PH_A2..PH_A6 (0..4)
  - a function mapping phase index to the 5-bit one-hot code
- One sub-module, cordic_sat_counter: parameterised-width saturating incrementer with synchronous clear. It is used for err_cnt; iter and retry_cnt are plain counters inside the FSM.
- The checker itself is instantiated by the parent, not inside this block.

## Test plan
- Clean run: ITERS=8, bench model returns d=1 during v and (d,dn)=(0,1) otherwise. Required: done at T+42, pass=1, fault=0, err_cnt=0, phase lines cycle a2→a6 eight times.
- Single mismatch at iter 3, phase a4, then clean. Required: err_cnt=1, retry_cnt=1, iter 3 restarts at a2, pass=1, done at T+42+1+3=T+46.
- Persistent mismatch at iter 0, phase a2, with MAX_RETRY=2. Required: three mismatches, err_cnt=3, retry_cnt=2, pass=0, fault=0.
- Dead checker: d=0 during SELFTEST. Required: fault=1, pass=0, done at T+2; inconsistent (1,1) at iter 5, phase a3 also gives fault=1.
- Control edges:
  - start pulsed while busy is ignored.
  - rst asserted mid-CHECK: next cycle all outputs 0 in IDLE, no done pulse.
  - ERRW=2 with MAX_RETRY=5 and persistent mismatch: err_cnt saturates at 3.
